// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the instruction memory address from the PC,
// registers the fetched word for decode, squashes the pipe for a number of
// bubble cycles after a taken branch, and parks in HALT on the halt opcode.
module fetch_stage #(
    parameter int              BUS          = 4,
    parameter int              IW           = 16,
    parameter int              FLUSH_CYCLES = 2,
    parameter logic [IW-1:0]   HALT_INSTR   = {IW{1'b1}}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           branch_nop,
    input  logic [BUS-1:0] jump_address,
    input  logic [IW-1:0]  imem_data,
    output logic [BUS-1:0] imem_addr,
    output logic [BUS-1:0] if_pc,
    output logic [IW-1:0]  if_instr,
    output logic           if_valid,
    output logic           halted
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    // The counter is loaded one below the bubble count because the FLUSH
    // cycle that sees zero is itself the last bubble.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [BUS-1:0] pc_q, pc_d;
    logic [BUS-1:0] if_pc_q, if_pc_d;
    logic [IW-1:0]  if_instr_q, if_instr_d;
    logic           if_valid_q, if_valid_d;

    // Next-state logic: a branch beats a stall, which beats the state's own action.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;

        if (branch_nop) begin
            pc_d       = jump_address;
            if_valid_d = 1'b0;
            if_instr_d = '0;
            cnt_d      = FLUSH_LOAD;
            state_d    = FLUSH;
        end else if (!stall) begin
            case (state_q)
                RUN: begin
                    if_pc_d    = pc_q;
                    if_instr_d = imem_data;
                    if_valid_d = 1'b1;
                    if (imem_data == HALT_INSTR) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + BUS'(1);
                    end
                end
                FLUSH: begin
                    if_valid_d = 1'b0;
                    if (cnt_q == 3'd0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                HALT: begin
                    if_valid_d = 1'b0;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // State register with synchronous reset that also discards any pending branch target.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= 3'd0;
            pc_q       <= '0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign if_valid  = if_valid_q;
    assign halted    = (state_q == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int          FLUSH_N = 2;
    localparam logic [15:0] HALT_OP = 16'hFFFF;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_nop;
    logic [3:0]  jump_address;
    logic [15:0] imem_data;
    logic [3:0]  imem_addr;
    logic [3:0]  if_pc;
    logic [15:0] if_instr;
    logic        if_valid;
    logic        halted;

    logic [15:0] mem [16];

    int compareCount = 0;
    int errorCount   = 0;
    string phase = "init";

    // Reference model state: what decode should see after each clock edge.
    int          mPc;
    logic [3:0]  mIfPc;
    logic [15:0] mIfInstr;
    bit          mIfValid;
    bit          mHalted;
    int          mFlushLeft;

    fetch_stage #(
        .BUS(4),
        .IW(16),
        .FLUSH_CYCLES(FLUSH_N),
        .HALT_INSTR(HALT_OP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .branch_nop(branch_nop),
        .jump_address(jump_address),
        .imem_data(imem_data),
        .imem_addr(imem_addr),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .if_valid(if_valid),
        .halted(halted)
    );

    // Instruction memory answers combinationally at the requested address.
    assign imem_data = mem[imem_addr];

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            errorCount++;
            $error("[TB] FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model by the same rules, then compare after the edge.
    task automatic applyStimulus(input bit r, input bit b, input bit s, input logic [3:0] j);
        rst          = r;
        branch_nop   = b;
        stall        = s;
        jump_address = j;
        if (r) begin
            mPc = 0; mIfPc = 4'h0; mIfInstr = 16'h0; mIfValid = 0; mHalted = 0; mFlushLeft = 0;
        end else if (b) begin
            mPc = int'(j); mIfValid = 0; mIfInstr = 16'h0; mFlushLeft = FLUSH_N; mHalted = 0;
        end else if (!s) begin
            if (mFlushLeft > 0) begin
                mFlushLeft--;
                mIfValid = 0;
            end else if (mHalted) begin
                mIfValid = 0;
            end else begin
                mIfPc    = 4'(mPc);
                mIfInstr = mem[mPc];
                mIfValid = 1;
                if (mem[mPc] == HALT_OP) mHalted = 1;
                else mPc = (mPc + 1) % 16;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("imem_addr", 32'(imem_addr), 32'(mPc));
        checkOutput("if_pc",     32'(if_pc),     32'(mIfPc));
        checkOutput("if_instr",  32'(if_instr),  32'(mIfInstr));
        checkOutput("if_valid",  32'(if_valid),  32'(mIfValid));
        checkOutput("halted",    32'(halted),    32'(mHalted));
    endtask

    // Directed scenarios first, then randomized traffic, then the summary.
    initial begin
        rst = 1'b1; stall = 1'b0; branch_nop = 1'b0; jump_address = 4'h0;
        mPc = 0; mIfPc = 4'h0; mIfInstr = 16'h0; mIfValid = 0; mHalted = 0; mFlushLeft = 0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);

        phase = "reset";
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(1, 1, 1, 4'h7);

        phase = "sequential";
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 4'h0);

        phase = "branch";
        applyStimulus(1, 0, 0, 4'h0);
        applyStimulus(0, 0, 0, 4'h0);
        applyStimulus(0, 1, 0, 4'h2);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 4'h0);

        phase = "stall";
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 4'h0);
        applyStimulus(0, 1, 1, 4'h7);
        applyStimulus(0, 0, 1, 4'h0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 4'h0);

        phase = "wrap";
        applyStimulus(0, 1, 0, 4'hE);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 4'h0);

        phase = "halt";
        mem[5] = HALT_OP;
        applyStimulus(0, 1, 0, 4'h3);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 4'h0);
        applyStimulus(0, 0, 1, 4'h0);
        for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 4'h0);
        applyStimulus(0, 1, 0, 4'h0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 4'h0);

        phase = "flush_redirect";
        applyStimulus(0, 1, 0, 4'hA);
        applyStimulus(0, 1, 0, 4'hC);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 4'h0);

        phase = "reset_in_flush";
        applyStimulus(0, 1, 0, 4'h9);
        applyStimulus(1, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 4'h0);

        phase = "random";
        for (int i = 0; i < 16; i++) mem[i] = ($urandom_range(0, 7) == 0) ? HALT_OP : 16'($urandom);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                mem[$urandom_range(0, 15)] = ($urandom_range(0, 5) == 0) ? HALT_OP : 16'($urandom);
            end
            applyStimulus($urandom_range(0, 49) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0,
                          4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errorCount);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter BUS, default 4: program counter and jump address width.
REQ-002 SHALL have parameter IW, default 16: instruction word width.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 2 (legal 1..7): bubble cycles inserted per taken branch.
REQ-004 SHALL have parameter HALT_INSTR, default all-ones IW bits: opcode that stops fetch.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL provide port stall, input, 1 bit: decode cannot accept; hold fetch.
REQ-009 SHALL provide port branch_nop, input, 1 bit: taken-branch/squash indication from the branch unit.
REQ-010 SHALL provide port jump_address, input, BUS bits: branch target, sampled only when branch_nop=1.
REQ-011 SHALL provide port imem_data, input, IW bits: instruction read combinationally at imem_addr.
REQ-012 SHALL provide port imem_addr, output, BUS bits: equals the PC register, combinational.
REQ-013 SHALL provide port if_pc, output, BUS bits: registered PC of the instruction in if_instr.
REQ-014 SHALL provide port if_instr, output, IW bits: registered instruction to decode.
REQ-015 SHALL provide port if_valid, output, 1 bit: if_instr is a real instruction (0 = bubble).
REQ-016 SHALL provide port halted, output, 1 bit: high while in state HALT.

Function
REQ-017 SHALL implement states RUN, FLUSH, HALT plus a 3-bit bubble counter.
REQ-018 SHALL evaluate per cycle with priority rst > branch_nop > stall > state action.
REQ-019 RUN, no stall, imem_data != HALT_INSTR: if_pc<=pc, if_instr<=imem_data, if_valid<=1, pc<=pc+1.
REQ-020 SHALL increment PC modulo 2^BUS (4'hF+1 -> 4'h0), no overflow flag.
REQ-021 RUN, no stall, imem_data == HALT_INSTR: latch it with if_valid<=1, pc holds, next state HALT.
REQ-022 stall=1, no branch_nop: pc, if_pc, if_instr, if_valid, counter, state all hold.
REQ-023 branch_nop=1 in any state, even with stall=1: pc<=jump_address, if_valid<=0, if_instr<=0, counter<=FLUSH_CYCLES-1, next state FLUSH.
REQ-024 FLUSH: if_valid<=0, pc holds at target; counter decrements each unstalled cycle; at counter 0, next state RUN.
REQ-025 FLUSH_CYCLES=1: FLUSH lasts exactly one cycle after the branch cycle; total bubbles always equal FLUSH_CYCLES.
REQ-026 branch_nop during FLUSH SHALL reload target and counter; the newest target wins.
REQ-027 HALT: if_valid<=0, pc holds, halted=1; exit only via branch_nop (to FLUSH) or rst.
REQ-028 First valid instruction after a branch SHALL be imem[jump_address] with if_pc=jump_address.
REQ-029 imem_data SHALL be ignored in FLUSH and HALT, including HALT_INSTR encodings.

Reset
REQ-030 rst=1 at a clock edge: pc=0, if_pc=0, if_instr=0, if_valid=0, halted=0, counter=0, state RUN, overriding branch_nop and stall.
REQ-031 Reset mid-FLUSH or in HALT SHALL fully abandon the pending target; the first cycle after reset fetches address 0.

Verification
REQ-032 Sequential: reset, imem[0..3]=16'h1000..16'h1003 -> if_pc 0,1,2,3 with if_valid=1 on consecutive cycles after reset.
REQ-033 Branch: at pc=4'h1, branch_nop=1, jump_address=4'h2 -> two cycles if_valid=0, then if_pc=4'h2 with if_instr=imem[2].
REQ-034 Stall and branch-over-stall: stall=1 for 3 cycles -> outputs frozen; branch_nop=1 with stall=1 -> pc=target, flush starts.
REQ-035 Wrap: pc=4'hF, no stall -> if_pc=4'hF, then next fetch if_pc=4'h0.
REQ-036 Halt: imem[5]=16'hFFFF -> if_instr=16'hFFFF valid once, halted=1, pc stays 5; branch_nop with target 4'h0 -> halted=0, refetch from 0.
REQ-037 Reset in FLUSH: branch to 4'h9, rst on next cycle -> all outputs zero, first fetch if_pc=4'h0.
